mc_ctrl_fsm: RTL

Multicycle successor to the single-cycle control path. An FSM sequences fetch, decode, execute, memory and writeback over several cycles. It shares one memory port for instruction and data and holds each memory access until the memory returns a ready handshake. It drives the datapath select/enable signals and sits between the instruction register and the shared datapath in the multicycle processor top.

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_mem_wait.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle control path
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WR   = 4'd4,
        ST_WB_MEM   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_WB_I     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_FAULT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States that own the shared memory port and therefore run the wait counter.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// rtl/mc_mem_wait.sv - per-access wait counter with timeout detection for the shared memory port
module mc_mem_wait #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clear,
    input  logic i_req,
    input  logic i_ready,
    output logic o_done,
    output logic o_timeout
);

    localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(MEM_TIMEOUT - 1);

    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && i_req && !i_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // a ready in that same cycle completes the access instead.
    assign o_done    = i_req & i_ready;
    assign o_timeout = i_req & ~i_ready & (r_cnt == LAST_WAIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle control FSM over a shared memory port; MC_CTRL_PERF_EN adds perf counters
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic [1:0]          alu_op,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                fault,
    output logic [3:0]          state_out
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    cyc_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    state_t r_state;
    state_t w_next;
    logic   w_done;
    logic   w_timeout;
    logic   w_clear;
    logic   w_mem_state;
    logic   w_unused_zero;

    // The zero flag gates pc_write_cond inside the datapath, not here.
    assign w_unused_zero = zero;

    assign w_mem_state = is_mem_state(r_state);
    assign w_clear     = run && (w_next != r_state) && is_mem_state(w_next);

    mc_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMO_W      (TMO_W)
    ) u_mem_wait (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (run),
        .i_clear  (w_clear),
        .i_req    (w_mem_state),
        .i_ready  (mem_ready),
        .o_done   (w_done),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (run) begin
            case (r_state)
                ST_FETCH: begin
                    if (w_done)         w_next = ST_DECODE;
                    else if (w_timeout) w_next = ST_FAULT;
                end
                ST_DECODE: begin
                    case (opcode)
                        OPCODE_W'(OP_RTYPE):               w_next = ST_EXEC_R;
                        OPCODE_W'(OP_LW), OPCODE_W'(OP_SW): w_next = ST_MEM_ADDR;
                        OPCODE_W'(OP_BEQ):                 w_next = ST_BRANCH;
                        OPCODE_W'(OP_J):                   w_next = ST_JUMP;
                        OPCODE_W'(OP_ADDI):                w_next = ST_EXEC_I;
                        default:                           w_next = ST_FAULT;
                    endcase
                end
                ST_MEM_ADDR: w_next = (opcode == OPCODE_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD: begin
                    if (w_done)         w_next = ST_WB_MEM;
                    else if (w_timeout) w_next = ST_FAULT;
                end
                ST_MEM_WR: begin
                    if (w_done)         w_next = ST_FETCH;
                    else if (w_timeout) w_next = ST_FAULT;
                end
                ST_EXEC_R:  w_next = ST_WB_R;
                ST_EXEC_I:  w_next = ST_WB_I;
                ST_WB_MEM, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: w_next = ST_FETCH;
                ST_FAULT:   w_next = ST_FAULT;
                default:    w_next = ST_FAULT;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted so an access in flight drops at once.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        fault         = 1'b0;
        if (rst) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = run & mem_ready;
                    pc_write  = run & mem_ready;
                end
                ST_DECODE:   alu_src_b = SRCB_IMM_SH2;
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                ST_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_WB_I:     reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                ST_FAULT:    fault = 1'b1;
                default:     fault = 1'b1;
            endcase
        end
    end

    assign state_out = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt   <= '0;
            r_instr_cnt <= '0;
        end else begin
            if (run && (r_state != ST_FAULT)) begin
                r_cyc_cnt <= r_cyc_cnt + 1'b1;
            end
            if (run && (w_next == ST_FETCH) && (r_state != ST_FETCH)) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule
